// File: rtl/axi_axis_fifo_reader_pkg.sv
// axi_axis_fifo_reader_pkg: register offsets and bit positions shared by the FIFO reader
package axi_axis_fifo_reader_pkg;
  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam logic [1:0] REG_DEPTH   = 2'd3;
  localparam int OVF_BIT     = 31;
  localparam int EMPTY_BIT   = 16;
  localparam int COUNT_LSB   = 0;
  localparam int COUNT_W     = 16;
  localparam int FLUSH_BIT   = 0;
  localparam int CLR_OVF_BIT = 1;
endpackage

// File: rtl/axi_axis_fifo_reader_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered count, flush and combinational head output
module sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0] count_q, count_d;
  logic do_push, do_pop;
  assign full  = count_q == (DEPTH_LOG2+1)'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];
  // flush overrides both sides; the popped word is still read from dout this cycle
  always_comb begin
    do_push  = push & ~full & ~flush;
    do_pop   = pop & ~empty & ~flush;
    wr_ptr_d = flush ? '0 : wr_ptr_q + DEPTH_LOG2'(do_push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + DEPTH_LOG2'(do_pop);
    count_d  = flush ? '0 : count_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/axi_axis_fifo_reader.sv
// axi_axis_fifo_reader: AXI4-Lite slave draining a buffered AXI4-Stream input through a FIFO
module axi_axis_fifo_reader
  import axi_axis_fifo_reader_pkg::*;
#(
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_ADDR_WIDTH  = 12,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int TWOS_COMPL      = 1,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int DROP_WHEN_FULL  = 1
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_awaddr,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]  s_axi_wdata,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_araddr,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]  s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready
);
  localparam logic [AXI_DATA_WIDTH-1:0] DEPTH_WORD = AXI_DATA_WIDTH'(1) << FIFO_DEPTH_LOG2;
  logic [AXI_DATA_WIDTH-1:0] s_word, dout, status, rd_word, rdata_q, rdata_d;
  logic [FIFO_DEPTH_LOG2:0] count;
  logic full, empty, push, pop, flush, clr_ovf, ovf_evt, wr_hs, ar_hs, ctrl_wr;
  logic ovf_q, ovf_d, rvalid_q, rvalid_d, bvalid_q, bvalid_d;
  logic unused_bits;
  if (AXIS_DATA_WIDTH == AXI_DATA_WIDTH) begin : g_eq
    assign s_word = s_axis_tdata;
  end else if (AXIS_DATA_WIDTH > AXI_DATA_WIDTH) begin : g_trunc
    logic unused_lsb;
    assign s_word     = s_axis_tdata[AXIS_DATA_WIDTH-1 -: AXI_DATA_WIDTH];
    assign unused_lsb = ^s_axis_tdata[AXIS_DATA_WIDTH-AXI_DATA_WIDTH-1:0];
  end else begin : g_ext
    assign s_word = {{(AXI_DATA_WIDTH-AXIS_DATA_WIDTH){(TWOS_COMPL != 0) & s_axis_tdata[AXIS_DATA_WIDTH-1]}}, s_axis_tdata};
  end
  assign unused_bits = ^{s_axi_awaddr[AXI_ADDR_WIDTH-1:4], s_axi_awaddr[1:0],
                         s_axi_araddr[AXI_ADDR_WIDTH-1:4], s_axi_araddr[1:0],
                         s_axi_wdata[AXI_DATA_WIDTH-1:2]};
  sync_fifo #(.WIDTH(AXI_DATA_WIDTH), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
    .clk(aclk), .rst_n(aresetn), .push(push), .pop(pop), .flush(flush), .din(s_word),
    .dout(dout), .full(full), .empty(empty), .count(count)
  );
  assign s_axis_tready = (DROP_WHEN_FULL != 0) | ~full;
  assign s_axi_awready = ~bvalid_q;
  assign s_axi_wready  = ~bvalid_q;
  assign s_axi_arready = ~rvalid_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_rresp   = 2'b00;
  always_comb begin
    wr_hs    = s_axi_awvalid & s_axi_wvalid & ~bvalid_q;
    ar_hs    = s_axi_arvalid & ~rvalid_q;
    ctrl_wr  = wr_hs & (s_axi_awaddr[3:2] == REG_CONTROL);
    flush    = ctrl_wr & s_axi_wdata[FLUSH_BIT];
    clr_ovf  = ctrl_wr & s_axi_wdata[CLR_OVF_BIT];
    push     = s_axis_tvalid & s_axis_tready & ~full;
    pop      = ar_hs & (s_axi_araddr[3:2] == REG_DATA) & ~empty;
    ovf_evt  = (DROP_WHEN_FULL != 0) & s_axis_tvalid & full;
    ovf_d    = ovf_evt ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
    status   = '0;
    status[OVF_BIT]   = ovf_q;
    status[EMPTY_BIT] = empty;
    status[COUNT_LSB +: COUNT_W] = COUNT_W'(count);
    rd_word  = s_axi_araddr[3:2] == REG_DATA   ? (empty ? '0 : dout) :
               s_axi_araddr[3:2] == REG_STATUS ? status :
               s_axi_araddr[3:2] == REG_DEPTH  ? DEPTH_WORD : '0;
    rdata_d  = ar_hs ? rd_word : rdata_q;
    rvalid_d = ar_hs | (rvalid_q & ~s_axi_rready);
    bvalid_d = wr_hs | (bvalid_q & ~s_axi_bready);
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ovf_q    <= 1'b0;
      rvalid_q <= 1'b0;
      bvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ovf_q    <= ovf_d;
      rvalid_q <= rvalid_d;
      bvalid_q <= bvalid_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule
